// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard sequencer: decode/EX/MEM status in,
// PC select, stall/flush controls and performance counters out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_read1_e_i;
    logic             id_read2_e_i;
    logic             id_jump_e_i;
    logic [4:0]       ex_rd_i;
    logic             ex_memread_i;
    logic             ex_branch_taken_i;
    logic             mem_busy_i;
    logic [1:0]       pc_sel_o;
    logic             stall_pc_o;
    logic             stall_if_id_o;
    logic             stall_id_ex_o;
    logic             flush_if_id_o;
    logic             flush_id_ex_o;
    logic             timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_read1_e_i, id_read2_e_i, id_jump_e_i,
        output ex_rd_i, ex_memread_i, ex_branch_taken_i, mem_busy_i,
        input  pc_sel_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
        input  flush_if_id_o, flush_id_ex_o, timeout_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_read1_e_i, id_read2_e_i, id_jump_e_i,
        input  ex_rd_i, ex_memread_i, ex_branch_taken_i, mem_busy_i,
        output pc_sel_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
        output flush_if_id_o, flush_id_ex_o, timeout_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use stalls, branch/jump redirect
// flushes and data-memory freezes, with saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    hazard_ctrl_if.slave hz
);
    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LIM = WCNT_W'(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_PRE = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StLuStall, StFlush, StMemWait} state_e;

    state_e            r_state, r_ret, w_state_d, w_ret_d, w_eff;
    logic [2:0]        r_fcnt, w_fcnt_d;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
    logic              w_load_use;
    logic [1:0]        w_pc_sel;
    logic              w_stall_pc, w_stall_if_id, w_stall_id_ex;
    logic              w_flush_if_id, w_flush_id_ex;

    always_comb begin
        w_load_use = hz.ex_memread_i && (hz.ex_rd_i != 5'd0) &&
                     ((hz.id_read1_e_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                      (hz.id_read2_e_i && (hz.id_rs2_i == hz.ex_rd_i)));
        // The cycle that leaves MEM_WAIT behaves exactly like the state it returns to.
        w_eff = (r_state == StMemWait && !hz.mem_busy_i) ? r_ret : r_state;

        w_state_d     = r_state;
        w_ret_d       = r_ret;
        w_fcnt_d      = r_fcnt;
        w_pc_sel      = 2'b00;
        w_stall_pc    = 1'b0;
        w_stall_if_id = 1'b0;
        w_stall_id_ex = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;

        unique case (w_eff)
            StRun, StLuStall: begin
                w_state_d = StRun;
                if (hz.mem_busy_i) begin
                    {w_stall_pc, w_stall_if_id, w_stall_id_ex} = 3'b111;
                    w_ret_d   = StRun;
                    w_state_d = StMemWait;
                end else if (hz.ex_branch_taken_i) begin
                    w_pc_sel = 2'b10;
                    {w_flush_if_id, w_flush_id_ex} = 2'b11;
                    if (FLUSH_CYCLES > 1) begin
                        w_fcnt_d  = FCNT_INIT;
                        w_state_d = StFlush;
                    end
                end else if (w_load_use && (w_eff == StRun)) begin
                    {w_stall_pc, w_stall_if_id, w_flush_id_ex} = 3'b111;
                    w_state_d = StLuStall;
                end else if (hz.id_jump_e_i) begin
                    w_pc_sel      = 2'b01;
                    w_flush_if_id = 1'b1;
                end
            end
            StFlush: begin
                if (hz.mem_busy_i) begin
                    {w_stall_pc, w_stall_if_id, w_stall_id_ex} = 3'b111;
                    w_ret_d   = StFlush;
                    w_state_d = StMemWait;
                end else begin
                    {w_flush_if_id, w_flush_id_ex} = 2'b11;
                    w_fcnt_d  = r_fcnt - 3'd1;
                    w_state_d = (r_fcnt == 3'd1) ? StRun : StFlush;
                end
            end
            StMemWait: begin
                {w_stall_pc, w_stall_if_id, w_stall_id_ex} = 3'b111;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StRun;
            r_ret       <= StRun;
            r_fcnt      <= '0;
            r_wcnt      <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            r_ret   <= w_ret_d;
            r_fcnt  <= w_fcnt_d;
            if (r_state == StMemWait) begin
                if (hz.mem_busy_i) begin
                    if (r_wcnt != WCNT_LIM) r_wcnt <= r_wcnt + WCNT_W'(1);
                    if (r_wcnt == WCNT_PRE) r_timeout <= 1'b1;
                end else begin
                    r_wcnt <= '0;
                end
            end
            if (w_stall_pc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if ((w_flush_if_id || w_flush_id_ex) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // Mealy controls are forced low while reset is held, independent of inputs.
    assign hz.pc_sel_o      = rst_i ? 2'b00 : w_pc_sel;
    assign hz.stall_pc_o    = !rst_i && w_stall_pc;
    assign hz.stall_if_id_o = !rst_i && w_stall_if_id;
    assign hz.stall_id_ex_o = !rst_i && w_stall_id_ex;
    assign hz.flush_if_id_o = !rst_i && w_flush_if_id;
    assign hz.flush_id_ex_o = !rst_i && w_flush_id_ex;
    assign hz.timeout_o     = r_timeout;
    assign hz.stall_cnt_o   = r_stall_cnt;
    assign hz.flush_cnt_o   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances with different parameters share the
// stimulus; each step queues the expected outputs of the selected instance.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1, rs2, rd;
    logic       r1e, r2e, jump, memread, branch, busy;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(3))  ifa ();
    hazard_ctrl_if #(.CNT_W(16)) ifb ();
    hazard_ctrl_if #(.CNT_W(16)) ifc ();

    hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(3))
        dut_a (.clk_i(clk), .rst_i(rst), .hz(ifa.slave));
    hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(255), .CNT_W(16))
        dut_b (.clk_i(clk), .rst_i(rst), .hz(ifb.slave));
    hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(255), .CNT_W(16))
        dut_c (.clk_i(clk), .rst_i(rst), .hz(ifc.slave));

    assign ifa.id_rs1_i = rs1;      assign ifb.id_rs1_i = rs1;      assign ifc.id_rs1_i = rs1;
    assign ifa.id_rs2_i = rs2;      assign ifb.id_rs2_i = rs2;      assign ifc.id_rs2_i = rs2;
    assign ifa.id_read1_e_i = r1e;  assign ifb.id_read1_e_i = r1e;  assign ifc.id_read1_e_i = r1e;
    assign ifa.id_read2_e_i = r2e;  assign ifb.id_read2_e_i = r2e;  assign ifc.id_read2_e_i = r2e;
    assign ifa.id_jump_e_i = jump;  assign ifb.id_jump_e_i = jump;  assign ifc.id_jump_e_i = jump;
    assign ifa.ex_rd_i = rd;        assign ifb.ex_rd_i = rd;        assign ifc.ex_rd_i = rd;
    assign ifa.ex_memread_i = memread;
    assign ifb.ex_memread_i = memread;
    assign ifc.ex_memread_i = memread;
    assign ifa.ex_branch_taken_i = branch;
    assign ifb.ex_branch_taken_i = branch;
    assign ifc.ex_branch_taken_i = branch;
    assign ifa.mem_busy_i = busy;   assign ifb.mem_busy_i = busy;   assign ifc.mem_busy_i = busy;

    int unsigned dsel;
    logic [1:0]  o_pc;
    logic [4:0]  o_ctl;
    logic        o_tmo;
    int          o_sc, o_fc;

    always_comb begin
        o_pc  = ifa.pc_sel_o;
        o_ctl = {ifa.stall_pc_o, ifa.stall_if_id_o, ifa.stall_id_ex_o,
                 ifa.flush_if_id_o, ifa.flush_id_ex_o};
        o_tmo = ifa.timeout_o;
        o_sc  = int'(ifa.stall_cnt_o);
        o_fc  = int'(ifa.flush_cnt_o);
        if (dsel == 1) begin
            o_pc  = ifb.pc_sel_o;
            o_ctl = {ifb.stall_pc_o, ifb.stall_if_id_o, ifb.stall_id_ex_o,
                     ifb.flush_if_id_o, ifb.flush_id_ex_o};
            o_tmo = ifb.timeout_o;
            o_sc  = int'(ifb.stall_cnt_o);
            o_fc  = int'(ifb.flush_cnt_o);
        end else if (dsel == 2) begin
            o_pc  = ifc.pc_sel_o;
            o_ctl = {ifc.stall_pc_o, ifc.stall_if_id_o, ifc.stall_id_ex_o,
                     ifc.flush_if_id_o, ifc.flush_id_ex_o};
            o_tmo = ifc.timeout_o;
            o_sc  = int'(ifc.stall_cnt_o);
            o_fc  = int'(ifc.flush_cnt_o);
        end
    end

    typedef struct {
        string      tag;
        logic [1:0] pc;
        logic [4:0] ctl;
        logic       tmo;
        int         sc;
        int         fc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // ctl = {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex}
    task automatic step(input string tag, input logic [1:0] pc, input logic [4:0] ctl,
                        input logic tmo, input int sc, input int fc);
        exp_t e;
        sb.push_back('{tag: tag, pc: pc, ctl: ctl, tmo: tmo, sc: sc, fc: fc});
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        assert ({o_pc, o_ctl, o_tmo} === {e.pc, e.ctl, e.tmo}) else begin
            n_bad++;
            $error("FAIL %s ctl: got pc=%b ctl=%b tmo=%b want pc=%b ctl=%b tmo=%b",
                   e.tag, o_pc, o_ctl, o_tmo, e.pc, e.ctl, e.tmo);
        end
        n_cmp++;
        assert (o_sc === e.sc) else begin
            n_bad++;
            $error("FAIL %s stall_cnt: got %0d want %0d", e.tag, o_sc, e.sc);
        end
        n_cmp++;
        assert (o_fc === e.fc) else begin
            n_bad++;
            $error("FAIL %s flush_cnt: got %0d want %0d", e.tag, o_fc, e.fc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        rs1 = '0; rs2 = '0; rd = '0;
        r1e = 1'b0; r2e = 1'b0; jump = 1'b0; memread = 1'b0; branch = 1'b0; busy = 1'b0;
    endtask

    task automatic do_reset(input int unsigned d);
        dsel = d;
        rst  = 1'b1;
        memread = 1'b1; rd = 5'd5; rs1 = 5'd5; r1e = 1'b1;
        branch = 1'b1; jump = 1'b1; busy = 1'b1;
        step("in_reset", 2'b00, 5'b00000, 1'b0, 0, 0);
        clear();
        rst = 1'b0;
    endtask

    initial begin
        clear();
        dsel = 0;
        @(posedge clk);
        #1;

        // Load-use, jump and their interaction (FLUSH_CYCLES=1, CNT_W=3)
        do_reset(0);
        memread = 1'b1; rd = 5'd5; rs1 = 5'd5; r1e = 1'b1;
        step("lu", 2'b00, 5'b11001, 1'b0, 0, 0);
        step("lu_masked", 2'b00, 5'b00000, 1'b0, 1, 1);
        clear();
        step("lu_idle", 2'b00, 5'b00000, 1'b0, 1, 1);
        memread = 1'b1; rd = 5'd0; rs1 = 5'd0; r1e = 1'b1;
        step("lu_x0", 2'b00, 5'b00000, 1'b0, 1, 1);
        clear();
        memread = 1'b1; rd = 5'd7; rs2 = 5'd7; r2e = 1'b1;
        step("lu_rs2", 2'b00, 5'b11001, 1'b0, 1, 1);
        clear();
        step("lu_rs2_next", 2'b00, 5'b00000, 1'b0, 2, 2);
        memread = 1'b1; rd = 5'd7; rs2 = 5'd7; r2e = 1'b0;
        step("lu_no_rden", 2'b00, 5'b00000, 1'b0, 2, 2);
        clear();
        jump = 1'b1;
        step("jmp", 2'b01, 5'b00010, 1'b0, 2, 2);
        clear();
        step("jmp_next", 2'b00, 5'b00000, 1'b0, 2, 3);
        memread = 1'b1; rd = 5'd3; rs1 = 5'd3; r1e = 1'b1; jump = 1'b1;
        step("lu_over_jmp", 2'b00, 5'b11001, 1'b0, 2, 3);
        memread = 1'b0;
        step("lustall_jmp", 2'b01, 5'b00010, 1'b0, 3, 4);
        clear();
        step("lustall_done", 2'b00, 5'b00000, 1'b0, 3, 5);

        // Branch beats load-use, FLUSH_CYCLES=2
        do_reset(1);
        branch = 1'b1; memread = 1'b1; rd = 5'd5; rs1 = 5'd5; r1e = 1'b1;
        step("br_lu", 2'b10, 5'b00011, 1'b0, 0, 0);
        step("br_flush2", 2'b00, 5'b00011, 1'b0, 0, 1);
        clear();
        step("br_done", 2'b00, 5'b00000, 1'b0, 0, 2);
        busy = 1'b1; branch = 1'b1;
        step("busy_over_br", 2'b00, 5'b11100, 1'b0, 0, 2);
        clear();
        step("busy_release", 2'b00, 5'b00000, 1'b0, 1, 2);

        // Freeze inside a flush sequence, FLUSH_CYCLES=3
        do_reset(2);
        branch = 1'b1;
        step("c_br", 2'b10, 5'b00011, 1'b0, 0, 0);
        branch = 1'b0; busy = 1'b1;
        step("c_frz1", 2'b00, 5'b11100, 1'b0, 0, 1);
        step("c_frz2", 2'b00, 5'b11100, 1'b0, 1, 1);
        step("c_frz3", 2'b00, 5'b11100, 1'b0, 2, 1);
        busy = 1'b0;
        step("c_flush2", 2'b00, 5'b00011, 1'b0, 3, 1);
        step("c_flush3", 2'b00, 5'b00011, 1'b0, 3, 2);
        step("c_run", 2'b00, 5'b00000, 1'b0, 3, 3);

        // Memory timeout (MEM_TIMEOUT=4) and counter saturation (CNT_W=3)
        do_reset(0);
        busy = 1'b1;
        step("w0", 2'b00, 5'b11100, 1'b0, 0, 0);
        step("w1", 2'b00, 5'b11100, 1'b0, 1, 0);
        step("w2", 2'b00, 5'b11100, 1'b0, 2, 0);
        step("w3", 2'b00, 5'b11100, 1'b0, 3, 0);
        step("w4", 2'b00, 5'b11100, 1'b0, 4, 0);
        step("w5_tmo", 2'b00, 5'b11100, 1'b1, 5, 0);
        busy = 1'b0;
        step("w_release", 2'b00, 5'b00000, 1'b1, 6, 0);
        step("w_idle", 2'b00, 5'b00000, 1'b1, 6, 0);
        busy = 1'b1;
        step("s0", 2'b00, 5'b11100, 1'b1, 6, 0);
        step("s1", 2'b00, 5'b11100, 1'b1, 7, 0);
        step("s2_sat", 2'b00, 5'b11100, 1'b1, 7, 0);
        busy = 1'b0;
        step("s_release", 2'b00, 5'b00000, 1'b1, 7, 0);

        // Asynchronous reset in the middle of a freeze
        do_reset(0);
        busy = 1'b1;
        step("r_w0", 2'b00, 5'b11100, 1'b0, 0, 0);
        step("r_w1", 2'b00, 5'b11100, 1'b0, 1, 0);
        rst = 1'b1;
        step("r_async", 2'b00, 5'b00000, 1'b0, 0, 0);
        rst = 1'b0; busy = 1'b0; jump = 1'b1;
        step("r_run_jmp", 2'b01, 5'b00010, 1'b0, 0, 0);
        clear();
        step("r_run_idle", 2'b00, 5'b00000, 1'b0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
